// File: rtl/mem_arbiter.sv
// Two-master memory arbiter: M0 (core LSU) and M1 (debug/DMA) share one port.
// Same-cycle grant, optional bus lock with idle timeout, 1-cycle read return.
module mem_arbiter #(
   parameter int RR_EN        = 1,
   parameter int LOCK_TIMEOUT = 16
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_m0_req,
   input  logic        i_m0_lock,
   input  logic        i_m0_wren,
   input  logic [2:0]  i_m0_funct3,
   input  logic [31:0] i_m0_addr,
   input  logic [31:0] i_m0_wdata,
   output logic        o_m0_gnt,
   output logic        o_m0_rvalid,
   output logic [31:0] o_m0_rdata,
   input  logic        i_m1_req,
   input  logic        i_m1_lock,
   input  logic        i_m1_wren,
   input  logic [2:0]  i_m1_funct3,
   input  logic [31:0] i_m1_addr,
   input  logic [31:0] i_m1_wdata,
   output logic        o_m1_gnt,
   output logic        o_m1_rvalid,
   output logic [31:0] o_m1_rdata,
   output logic        o_mem_req,
   output logic        o_mem_wren,
   output logic [2:0]  o_mem_funct3,
   output logic [31:0] o_mem_addr,
   output logic [31:0] o_mem_wdata,
   input  logic [31:0] i_mem_rdata,
   output logic        o_owner,
   output logic        o_locked
);

   typedef enum logic [1:0] {
      IDLE,
      LOCK_M0,
      LOCK_M1
   } state_t;

   localparam logic [7:0] TIMEOUT = 8'(LOCK_TIMEOUT);

   state_t      state;
   logic        last_gnt;
   logic [7:0]  idle_cnt;
   logic        pend0;
   logic        pend1;
   logic [31:0] rdata0_q;
   logic [31:0] rdata1_q;
   logic        locked_q;
   logic        gnt0;
   logic        gnt1;
   logic        xfer0;
   logic        xfer1;
   logic        xfer_lock;
   logic        owner_req;

   // last_gnt=1 means M1 won the most recent transfer
   always_comb begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      if (i_reset) begin
         case (state)
            IDLE: begin
               if (i_m0_req && i_m1_req) begin
                  if (RR_EN != 0) begin
                     gnt0 = last_gnt;
                     gnt1 = !last_gnt;
                  end else begin
                     gnt0 = 1'b1;
                  end
               end else begin
                  gnt0 = i_m0_req;
                  gnt1 = i_m1_req;
               end
            end
            LOCK_M0: gnt0 = i_m0_req;
            LOCK_M1: gnt1 = i_m1_req;
            default: ;
         endcase
      end
   end

   assign xfer0     = i_m0_req && gnt0;
   assign xfer1     = i_m1_req && gnt1;
   assign xfer_lock = (xfer0 && i_m0_lock) || (xfer1 && i_m1_lock);
   assign owner_req = (state == LOCK_M0) ? i_m0_req : i_m1_req;

   assign o_m0_gnt  = gnt0;
   assign o_m1_gnt  = gnt1;
   assign o_mem_req = xfer0 || xfer1;
   assign o_owner   = xfer1;
   assign o_locked  = locked_q;

   always_comb begin
      o_mem_wren   = 1'b0;
      o_mem_funct3 = 3'd0;
      o_mem_addr   = 32'd0;
      o_mem_wdata  = 32'd0;
      if (xfer0) begin
         o_mem_wren   = i_m0_wren;
         o_mem_funct3 = i_m0_funct3;
         o_mem_addr   = i_m0_addr;
         o_mem_wdata  = i_m0_wdata;
      end else if (xfer1) begin
         o_mem_wren   = i_m1_wren;
         o_mem_funct3 = i_m1_funct3;
         o_mem_addr   = i_m1_addr;
         o_mem_wdata  = i_m1_wdata;
      end
   end

   assign o_m0_rvalid = pend0;
   assign o_m1_rvalid = pend1;
   assign o_m0_rdata  = pend0 ? i_mem_rdata : rdata0_q;
   assign o_m1_rdata  = pend1 ? i_mem_rdata : rdata1_q;

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         state    <= IDLE;
         last_gnt <= 1'b1;
         idle_cnt <= 8'd0;
         pend0    <= 1'b0;
         pend1    <= 1'b0;
         rdata0_q <= 32'd0;
         rdata1_q <= 32'd0;
         locked_q <= 1'b0;
      end else begin
         if (xfer0) begin
            last_gnt <= 1'b0;
         end else if (xfer1) begin
            last_gnt <= 1'b1;
         end
         pend0 <= xfer0 && !i_m0_wren;
         pend1 <= xfer1 && !i_m1_wren;
         if (pend0) begin
            rdata0_q <= i_mem_rdata;
         end
         if (pend1) begin
            rdata1_q <= i_mem_rdata;
         end
         case (state)
            IDLE: begin
               idle_cnt <= 8'd0;
               if (xfer0 && i_m0_lock) begin
                  state    <= LOCK_M0;
                  locked_q <= 1'b1;
               end else if (xfer1 && i_m1_lock) begin
                  state    <= LOCK_M1;
                  locked_q <= 1'b1;
               end
            end
            LOCK_M0, LOCK_M1: begin
               // owner request always transfers while locked
               if (owner_req) begin
                  idle_cnt <= 8'd0;
                  if (!xfer_lock) begin
                     state    <= IDLE;
                     locked_q <= 1'b0;
                  end
               end else if (idle_cnt + 8'd1 == TIMEOUT) begin
                  state    <= IDLE;
                  locked_q <= 1'b0;
                  idle_cnt <= 8'd0;
               end else begin
                  idle_cnt <= idle_cnt + 8'd1;
               end
            end
            default: begin
               state    <= IDLE;
               locked_q <= 1'b0;
               idle_cnt <= 8'd0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: round-robin and fixed-priority
// instances share stimulus and are checked against a behavioural model.
module tb_mem_arbiter;

   localparam int TO = 16;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic        m0_req, m0_lock, m0_wren;
   logic [2:0]  m0_f3;
   logic [31:0] m0_addr, m0_wdata;
   logic        m1_req, m1_lock, m1_wren;
   logic [2:0]  m1_f3;
   logic [31:0] m1_addr, m1_wdata;
   logic [31:0] mem_rdata;

   logic [1:0]  d_g0, d_g1, d_rv0, d_rv1;
   logic [1:0]  d_mreq, d_wren, d_owner, d_locked;
   logic [31:0] d_rd0 [2];
   logic [31:0] d_rd1 [2];
   logic [2:0]  d_f3 [2];
   logic [31:0] d_addr [2];
   logic [31:0] d_wdata [2];

   mem_arbiter #(.RR_EN(1), .LOCK_TIMEOUT(TO)) u_rr (
      .i_clk(clk), .i_reset(rst_n),
      .i_m0_req(m0_req), .i_m0_lock(m0_lock), .i_m0_wren(m0_wren),
      .i_m0_funct3(m0_f3), .i_m0_addr(m0_addr), .i_m0_wdata(m0_wdata),
      .o_m0_gnt(d_g0[0]), .o_m0_rvalid(d_rv0[0]), .o_m0_rdata(d_rd0[0]),
      .i_m1_req(m1_req), .i_m1_lock(m1_lock), .i_m1_wren(m1_wren),
      .i_m1_funct3(m1_f3), .i_m1_addr(m1_addr), .i_m1_wdata(m1_wdata),
      .o_m1_gnt(d_g1[0]), .o_m1_rvalid(d_rv1[0]), .o_m1_rdata(d_rd1[0]),
      .o_mem_req(d_mreq[0]), .o_mem_wren(d_wren[0]),
      .o_mem_funct3(d_f3[0]), .o_mem_addr(d_addr[0]),
      .o_mem_wdata(d_wdata[0]), .i_mem_rdata(mem_rdata),
      .o_owner(d_owner[0]), .o_locked(d_locked[0])
   );

   mem_arbiter #(.RR_EN(0), .LOCK_TIMEOUT(TO)) u_fp (
      .i_clk(clk), .i_reset(rst_n),
      .i_m0_req(m0_req), .i_m0_lock(m0_lock), .i_m0_wren(m0_wren),
      .i_m0_funct3(m0_f3), .i_m0_addr(m0_addr), .i_m0_wdata(m0_wdata),
      .o_m0_gnt(d_g0[1]), .o_m0_rvalid(d_rv0[1]), .o_m0_rdata(d_rd0[1]),
      .i_m1_req(m1_req), .i_m1_lock(m1_lock), .i_m1_wren(m1_wren),
      .i_m1_funct3(m1_f3), .i_m1_addr(m1_addr), .i_m1_wdata(m1_wdata),
      .o_m1_gnt(d_g1[1]), .o_m1_rvalid(d_rv1[1]), .o_m1_rdata(d_rd1[1]),
      .o_mem_req(d_mreq[1]), .o_mem_wren(d_wren[1]),
      .o_mem_funct3(d_f3[1]), .o_mem_addr(d_addr[1]),
      .o_mem_wdata(d_wdata[1]), .i_mem_rdata(mem_rdata),
      .o_owner(d_owner[1]), .o_locked(d_locked[1])
   );

   typedef struct packed {
      bit        rst;
      bit        r0, l0, w0;
      bit [2:0]  f0;
      bit [31:0] a0, d0;
      bit        r1, l1, w1;
      bit [2:0]  f1;
      bit [31:0] a1, d1;
      bit [31:0] rd_next;
   } stim_t;

   typedef struct packed {
      int        cyc;
      bit        inst;
      bit        rst;
      bit        g0, g1, mreq, wren;
      bit [2:0]  f3;
      bit [31:0] addr, wdata;
      bit        owner, locked;
   } exp_t;

   typedef struct packed {
      int        due;
      bit        inst;
      bit        id;
      bit [31:0] data;
   } rd_t;

   exp_t eq[$];
   rd_t  rq[$];
   int   cyc = 0;
   int   n_cmp = 0;
   int   n_err = 0;
   bit [31:0] nxt_rd = 32'd0;

   // model state per instance: lock owner (-1 none), idle count, last winner
   int m_lock [2] = '{-1, -1};
   int m_idle [2] = '{0, 0};
   bit m_last [2] = '{1'b1, 1'b1};

   task automatic chk(string nm, int inst, logic [63:0] act,
                      logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s inst%0d cyc%0d got %h want %h",
                  nm, inst, cyc, act, exp);
      end
   endtask

   function automatic stim_t idle_s();
      stim_t s;
      s = '0;
      s.rd_next = $urandom;
      return s;
   endfunction

   task automatic step(stim_t s);
      @(posedge clk);
      #1;
      cyc++;
      rst_n     = !s.rst;
      m0_req    = s.r0;  m0_lock = s.l0; m0_wren = s.w0;
      m0_f3     = s.f0;  m0_addr = s.a0; m0_wdata = s.d0;
      m1_req    = s.r1;  m1_lock = s.l1; m1_wren = s.w1;
      m1_f3     = s.f1;  m1_addr = s.a1; m1_wdata = s.d1;
      mem_rdata = nxt_rd;
      nxt_rd    = s.rd_next;
      if (s.rst) rq.delete();
      for (int k = 0; k < 2; k++) begin
         exp_t e;
         bit g0, g1, own_r, own_l;
         g0 = 1'b0;
         g1 = 1'b0;
         if (!s.rst) begin
            if (m_lock[k] == 0) g0 = s.r0;
            else if (m_lock[k] == 1) g1 = s.r1;
            else if (s.r0 && s.r1) begin
               if (k == 0) begin
                  g0 = m_last[k];
                  g1 = !m_last[k];
               end else begin
                  g0 = 1'b1;
               end
            end else begin
               g0 = s.r0;
               g1 = s.r1;
            end
         end
         e        = '0;
         e.cyc    = cyc;
         e.inst   = k[0];
         e.rst    = s.rst;
         e.g0     = g0;
         e.g1     = g1;
         e.mreq   = g0 | g1;
         e.owner  = g1;
         e.locked = !s.rst && (m_lock[k] != -1);
         if (g0) begin
            e.wren = s.w0; e.f3 = s.f0; e.addr = s.a0; e.wdata = s.d0;
         end else if (g1) begin
            e.wren = s.w1; e.f3 = s.f1; e.addr = s.a1; e.wdata = s.d1;
         end
         eq.push_back(e);
         if ((g0 && !s.w0) || (g1 && !s.w1))
            rq.push_back('{due: cyc + 1, inst: k[0], id: g1,
                           data: s.rd_next});
         if (s.rst) begin
            m_lock[k] = -1;
            m_idle[k] = 0;
            m_last[k] = 1'b1;
         end else begin
            if (g0) m_last[k] = 1'b0;
            else if (g1) m_last[k] = 1'b1;
            if (m_lock[k] == -1) begin
               if (g0 && s.l0) m_lock[k] = 0;
               else if (g1 && s.l1) m_lock[k] = 1;
            end else begin
               own_r = (m_lock[k] == 0) ? s.r0 : s.r1;
               own_l = (m_lock[k] == 0) ? s.l0 : s.l1;
               if (own_r) begin
                  m_idle[k] = 0;
                  if (!own_l) m_lock[k] = -1;
               end else begin
                  m_idle[k]++;
                  if (m_idle[k] >= TO) begin
                     m_lock[k] = -1;
                     m_idle[k] = 0;
                  end
               end
            end
         end
      end
   endtask

   // monitor: compares each presented cycle against queued expectations
   bit [31:0] hold [2][2];
   initial begin
      hold = '{'{32'd0, 32'd0}, '{32'd0, 32'd0}};
      forever begin
         @(negedge clk);
         while (eq.size() > 0 && eq[0].cyc <= cyc) begin
            exp_t e;
            int i;
            e = eq.pop_front();
            i = int'(e.inst);
            chk("gnt", i, {d_g0[i], d_g1[i]}, {e.g0, e.g1});
            chk("mem_req", i, d_mreq[i], e.mreq);
            chk("mem_wren", i, d_wren[i], e.wren);
            chk("mem_funct3", i, d_f3[i], e.f3);
            chk("mem_addr", i, d_addr[i], e.addr);
            chk("mem_wdata", i, d_wdata[i], e.wdata);
            chk("owner", i, d_owner[i], e.owner);
            chk("locked", i, d_locked[i], e.locked);
            if (e.rst) hold[i] = '{32'd0, 32'd0};
         end
         for (int i = 0; i < 2; i++) begin
            for (int x = 0; x < 2; x++) begin
               int fnd;
               logic rv;
               logic [31:0] rd;
               fnd = -1;
               foreach (rq[j])
                  if (rq[j].due == cyc && int'(rq[j].inst) == i &&
                      int'(rq[j].id) == x) fnd = j;
               rv = (x == 0) ? d_rv0[i] : d_rv1[i];
               rd = (x == 0) ? d_rd0[i] : d_rd1[i];
               chk(x == 0 ? "m0_rvalid" : "m1_rvalid", i, rv, fnd >= 0);
               if (fnd >= 0) begin
                  chk("rdata", i, rd, rq[fnd].data);
                  hold[i][x] = rq[fnd].data;
               end else begin
                  chk("rdata_hold", i, rd, hold[i][x]);
               end
            end
         end
         while (rq.size() > 0 && rq[0].due <= cyc) void'(rq.pop_front());
      end
   end

   initial begin
      stim_t s;
      int p;
      rst_n = 1'b0;
      {m0_req, m0_lock, m0_wren, m0_f3, m0_addr, m0_wdata} = '0;
      {m1_req, m1_lock, m1_wren, m1_f3, m1_addr, m1_wdata} = '0;
      mem_rdata = '0;
      // reset with both requesting: grants stay low
      s = idle_s(); s.rst = 1'b1; s.r0 = 1'b1; s.r1 = 1'b1;
      step(s);
      step(s);
      // contention right after reset
      repeat (4) begin
         s = idle_s(); s.r0 = 1'b1; s.r1 = 1'b1;
         s.a0 = $urandom; s.a1 = $urandom;
         step(s);
      end
      // M1 read routing
      s = idle_s(); s.r1 = 1'b1; s.a1 = 32'h0000_0010;
      s.rd_next = 32'hDEAD_BEEF;
      step(s);
      s = idle_s();
      step(s);
      // lock by M0 then timeout with M1 waiting
      s = idle_s(); s.r0 = 1'b1; s.l0 = 1'b1; s.w0 = 1'b1;
      step(s);
      repeat (20) begin
         s = idle_s(); s.r1 = 1'b1; s.a1 = $urandom;
         step(s);
      end
      // write masking
      s = idle_s();
      step(s);
      s.r0 = 1'b1; s.w0 = 1'b1; s.f0 = 3'b010;
      s.a0 = 32'h0000_7000; s.d0 = 32'h1234_5678;
      step(s);
      // reset while locked to M1 with a read in flight
      s = idle_s(); s.r1 = 1'b1; s.l1 = 1'b1;
      step(s);
      s = idle_s(); s.r1 = 1'b1; s.l1 = 1'b1; s.a1 = 32'h44;
      step(s);
      s = idle_s(); s.rst = 1'b1;
      step(s);
      s = idle_s(); s.r0 = 1'b1; s.r1 = 1'b1;
      step(s);
      step(idle_s());
      // randomized traffic with varying load
      for (int n = 0; n < 3000; n++) begin
         p = 25 * (((n / 200) % 4) + 1) - ((n / 200) % 4 == 3 ? 5 : 0);
         s = idle_s();
         s.rst = ($urandom_range(0, 299) == 0);
         s.r0 = ($urandom_range(0, 99) < p);
         s.r1 = ($urandom_range(0, 99) < p);
         s.l0 = ($urandom_range(0, 3) == 0);
         s.l1 = ($urandom_range(0, 3) == 0);
         s.w0 = $urandom_range(0, 1);
         s.w1 = $urandom_range(0, 1);
         s.f0 = 3'($urandom);
         s.f1 = 3'($urandom);
         s.a0 = $urandom; s.d0 = $urandom;
         s.a1 = $urandom; s.d1 = $urandom;
         step(s);
      end
      step(idle_s());
      step(idle_s());
      @(negedge clk);
      #1;
      chk("drain", 0, rq.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter RR_EN, default 1, meaning 1 = round-robin arbitration and 0 = fixed priority with M0 highest.
REQ-002 The block SHALL have parameter LOCK_TIMEOUT, default 16, meaning the number of consecutive idle owner cycles (range 1..255) after which a lock is released.
REQ-003 The block SHALL have one clock and an asynchronous active-low reset: i_clk  in  1  clock; i_reset  in  1  active-low asynchronous reset.
REQ-004 The block SHALL have the M0 (core LSU) port: i_m0_req in 1; i_m0_lock in 1; i_m0_wren in 1; i_m0_funct3 in 3; i_m0_addr in 32; i_m0_wdata in 32; o_m0_gnt out 1; o_m0_rvalid out 1; o_m0_rdata out 32.
REQ-005 The block SHALL have the M1 (debug/DMA) port, with the same signal list as the M0 port using the m1 prefix.
REQ-006 The block SHALL have the memory/IO side port: o_mem_req out 1; o_mem_wren out 1; o_mem_funct3 out 3; o_mem_addr out 32; o_mem_wdata out 32; i_mem_rdata in 32 (valid exactly 1 cycle after an accepted read).
REQ-007 The block SHALL have status outputs: o_owner out 1 (0 = M0, 1 = M1, meaningful only when o_mem_req=1); o_locked out 1.

Function
REQ-008 A transfer SHALL occur in any cycle where i_mX_req=1 and o_mX_gnt=1.
REQ-009 Grant SHALL be combinational in the same cycle as the request, with zero added latency.
REQ-010 At most one o_mX_gnt SHALL be high in any cycle.
REQ-011 The state machine SHALL have three states: IDLE, LOCK_M0 and LOCK_M1.
REQ-012 In IDLE, when exactly one master requests, that master SHALL be granted.
REQ-013 In IDLE, when both masters request and RR_EN=1, the master not granted on the most recent transfer SHALL be granted (last-grant register).
REQ-014 In IDLE, when both masters request and RR_EN=0, M0 SHALL be granted.
REQ-015 In IDLE, a transfer with i_mX_lock=1 SHALL move the state to LOCK_MX on the next edge.
REQ-016 In LOCK_MX, only MX SHALL be grantable; the other master's gnt SHALL be 0 even while it requests.
REQ-017 In LOCK_MX, an owner transfer with lock=0 SHALL return the state to IDLE on the next edge; that transfer is still completed.
REQ-018 In LOCK_MX, each cycle with owner req=0 SHALL increment an 8-bit idle counter; any owner transfer SHALL clear it.
REQ-019 When the idle counter reaches LOCK_TIMEOUT, the state SHALL return to IDLE on the next edge and the counter SHALL clear.
REQ-020 The last-grant register SHALL update on every transfer, including transfers in lock states.
REQ-021 o_mem_req SHALL equal the OR of the transfer conditions.
REQ-022 o_mem_wren, o_mem_funct3, o_mem_addr and o_mem_wdata SHALL be muxed from the granted master.
REQ-023 With no transfer, o_mem_wren, o_mem_funct3, o_mem_addr and o_mem_wdata SHALL all be 0, so no spurious write reaches the LSU.
REQ-024 A read transfer (wren=0) SHALL register the master ID, and in the following cycle that master's o_mX_rvalid SHALL be 1 and o_mX_rdata SHALL equal i_mem_rdata.
REQ-025 The other master's o_mX_rvalid SHALL be 0, and its o_mX_rdata SHALL hold its previous value.
REQ-026 A write transfer SHALL produce no rvalid.
REQ-027 Back-to-back reads, including reads from alternating masters, SHALL be supported at 1 transfer per cycle, each response landing exactly 1 cycle later.
REQ-028 o_locked SHALL be 1 in LOCK_M0 and LOCK_M1.
REQ-029 o_owner SHALL equal the granted master's ID while o_mem_req=1, and 0 otherwise.
REQ-030 The block SHALL perform no address decode, alignment check or data formatting; those belong downstream.

Reset
REQ-031 While i_reset=0, the following SHALL hold asynchronously: state IDLE; last-grant = M1 (so M0 wins the first contention); idle counter 0; pending-read flags 0; o_m0_rvalid=o_m1_rvalid=0; o_m0_rdata=o_m1_rdata=0; o_locked=0.
REQ-032 While i_reset=0, all o_mX_gnt and o_mem_req SHALL be forced to 0.
REQ-033 Reset asserted mid-lock or with a read pending SHALL abandon the lock and drop the response; no rvalid SHALL appear after release.
REQ-034 The first grant SHALL be possible in the first cycle after reset deasserts.

Verification
REQ-035 Contention with RR_EN=1: both masters hold req for 4 cycles after reset; required grants M0, M1, M0, M1.
REQ-036 Fixed priority with RR_EN=0: both masters hold req for 4 cycles; o_m0_gnt=1 in all 4 cycles.
REQ-037 Read routing: M1 reads addr 0x0000_0010, i_mem_rdata=0xDEAD_BEEF the next cycle; required o_m1_rvalid=1, o_m1_rdata=0xDEAD_BEEF, o_m0_rvalid=0.
REQ-038 Lock then timeout: M0 transfers with lock=1, then drops req while M1 requests; required o_m1_gnt=0 for 16 cycles, M1 granted on cycle 17 after the lock edge.
REQ-039 Write masking: no requests present; required o_mem_wren=0 and o_mem_addr=0. M0 writes 0x1234_5678 to 0x0000_7000 with funct3=010; required o_mem_* mirror those values in the same cycle.
REQ-040 Reset mid-lock: i_reset pulled low for 1 cycle while in LOCK_M1 with a read pending; required o_locked=0, no rvalid afterwards, and M0 wins the next contention.
